// File: rtl/cache_meta_mem.sv
// Valid/dirty/tag metadata array for the direct-mapped cache: registered lookup,
// single-line fill/mark/invalidate, and a flush engine that hands dirty lines to write-back.
module cache_meta_mem #(
    parameter int INDEX_LEN = 6,
    parameter int TAG_LEN   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lookup_en,
    input  logic [INDEX_LEN-1:0] lookup_index,
    input  logic [TAG_LEN-1:0]   lookup_tag,
    output logic                 hit,
    output logic                 valid_out,
    output logic                 dirty_out,
    output logic [TAG_LEN-1:0]   tag_out,
    input  logic                 fill_en,
    input  logic [INDEX_LEN-1:0] fill_index,
    input  logic [TAG_LEN-1:0]   fill_tag,
    input  logic                 fill_dirty,
    input  logic                 mark_en,
    input  logic [INDEX_LEN-1:0] mark_index,
    input  logic                 inval_en,
    input  logic [INDEX_LEN-1:0] inval_index,
    input  logic                 flush_req,
    output logic                 busy,
    output logic                 wb_valid,
    output logic [INDEX_LEN-1:0] wb_index,
    output logic [TAG_LEN-1:0]   wb_tag,
    input  logic                 wb_ready,
    output logic                 flush_done
);

    localparam int DEPTH = 1 << INDEX_LEN;

    typedef enum logic [1:0] {IDLE, SCAN, WB_WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [INDEX_LEN-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     dirty_q, dirty_d;
    logic [TAG_LEN-1:0]   tag_q [DEPTH];
    logic [TAG_LEN-1:0]   tag_d [DEPTH];

    logic                 hit_q, hit_d;
    logic                 valid_out_q, valid_out_d;
    logic                 dirty_out_q, dirty_out_d;
    logic [TAG_LEN-1:0]   tag_out_q, tag_out_d;

    logic                 ptr_last;

    assign ptr_last = (ptr_q == {INDEX_LEN{1'b1}});

    // Single-line writes only happen in IDLE; the flush engine owns the array otherwise.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        state_d = state_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                if (inval_en) begin
                    valid_d[inval_index] = 1'b0;
                    dirty_d[inval_index] = 1'b0;
                end else if (fill_en) begin
                    valid_d[fill_index] = 1'b1;
                    dirty_d[fill_index] = fill_dirty;
                    tag_d[fill_index]   = fill_tag;
                end else if (mark_en && valid_q[mark_index]) begin
                    dirty_d[mark_index] = 1'b1;
                end
                if (flush_req) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                end
            end
            SCAN: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                    state_d = WB_WAIT;
                end else begin
                    valid_d[ptr_q] = 1'b0;
                    dirty_d[ptr_q] = 1'b0;
                    tag_d[ptr_q]   = '0;
                    if (ptr_last) state_d = DONE;
                    else          ptr_d   = ptr_q + 1'b1;
                end
            end
            WB_WAIT: begin
                if (wb_ready) begin
                    valid_d[ptr_q] = 1'b0;
                    dirty_d[ptr_q] = 1'b0;
                    tag_d[ptr_q]   = '0;
                    if (ptr_last) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lookup reads the pre-write array contents and reports a blank line while flushing.
    always_comb begin
        hit_d       = hit_q;
        valid_out_d = valid_out_q;
        dirty_out_d = dirty_out_q;
        tag_out_d   = tag_out_q;
        if (lookup_en) begin
            if (state_q != IDLE) begin
                hit_d       = 1'b0;
                valid_out_d = 1'b0;
                dirty_out_d = 1'b0;
                tag_out_d   = '0;
            end else begin
                hit_d       = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
                valid_out_d = valid_q[lookup_index];
                dirty_out_d = dirty_q[lookup_index];
                tag_out_d   = tag_q[lookup_index];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
            hit_q       <= 1'b0;
            valid_out_q <= 1'b0;
            dirty_out_q <= 1'b0;
            tag_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            hit_q       <= hit_d;
            valid_out_q <= valid_out_d;
            dirty_out_q <= dirty_out_d;
            tag_out_q   <= tag_out_d;
        end
    end

    // Offer fields are gated so they read zero whenever no offer is pending.
    assign hit        = hit_q;
    assign valid_out  = valid_out_q;
    assign dirty_out  = dirty_out_q;
    assign tag_out    = tag_out_q;
    assign busy       = (state_q != IDLE);
    assign wb_valid   = (state_q == WB_WAIT);
    assign wb_index   = wb_valid ? ptr_q : '0;
    assign wb_tag     = wb_valid ? tag_q[ptr_q] : '0;
    assign flush_done = (state_q == DONE);

endmodule
